// File: rtl/change_dispenser.sv
// Payout sequencer: splits a latched change amount greedily into 5000/2000/1000
// dispense pulses, separated by PULSE_GAP idle cycles, and reports the counts.
module change_dispenser #(
  parameter int unsigned PULSE_GAP = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [18:0] amount,
  output logic        pulse5000,
  output logic        pulse2000,
  output logic        pulse1000,
  output logic        busy,
  output logic        done,
  output logic [6:0]  c_5000,
  output logic [7:0]  c_2000,
  output logic [8:0]  c_1000,
  output logic [9:0]  change_left
);

  typedef enum logic {IDLE, DISP} state_t;

  localparam logic [3:0]  GAP_LD = 4'(PULSE_GAP);
  localparam logic [18:0] D5000  = 19'd5000;
  localparam logic [18:0] D2000  = 19'd2000;
  localparam logic [18:0] D1000  = 19'd1000;

  state_t      state_q, state_d;
  logic [18:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        p5_q, p5_d, p2_q, p2_d, p1_q, p1_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [6:0]  c5_q, c5_d;
  logic [7:0]  c2_q, c2_d;
  logic [8:0]  c1_q, c1_d;
  logic [9:0]  cl_q, cl_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      p5_q    <= 1'b0;
      p2_q    <= 1'b0;
      p1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c5_q    <= '0;
      c2_q    <= '0;
      c1_q    <= '0;
      cl_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      p5_q    <= p5_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c5_q    <= c5_d;
      c2_q    <= c2_d;
      c1_q    <= c1_d;
      cl_q    <= cl_d;
    end
  end

  // Pulses and done are strobes: they default low every cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    p5_d    = 1'b0;
    p2_d    = 1'b0;
    p1_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c5_d    = c5_q;
    c2_d    = c2_q;
    c1_d    = c1_q;
    cl_d    = cl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = amount;
          gap_d   = '0;
          c5_d    = '0;
          c2_d    = '0;
          c1_d    = '0;
          cl_d    = '0;
          busy_d  = 1'b1;
          state_d = DISP;
        end
      end
      DISP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (rem_q >= D5000) begin
          p5_d  = 1'b1;
          rem_d = rem_q - D5000;
          c5_d  = c5_q + 7'd1;
          gap_d = GAP_LD;
        end else if (rem_q >= D2000) begin
          p2_d  = 1'b1;
          rem_d = rem_q - D2000;
          c2_d  = c2_q + 8'd1;
          gap_d = GAP_LD;
        end else if (rem_q >= D1000) begin
          p1_d  = 1'b1;
          rem_d = rem_q - D1000;
          c1_d  = c1_q + 9'd1;
          gap_d = GAP_LD;
        end else begin
          cl_d    = rem_q[9:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pulse5000   = p5_q;
  assign pulse2000   = p2_q;
  assign pulse1000   = p1_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign c_5000      = c5_q;
  assign c_2000      = c2_q;
  assign c_1000      = c1_q;
  assign change_left = cl_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (gap 3 and gap 1) checked every cycle
// against a schedule model, plus literal expectations for the directed cases.
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  st;
  logic [18:0] amt [2];
  logic [1:0]  p5, p2, p1, bz, dn;
  logic [6:0]  c5 [2];
  logic [7:0]  c2 [2];
  logic [8:0]  c1 [2];
  logic [9:0]  cl [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  change_dispenser #(.PULSE_GAP(3)) u3 (
    .clock(clock), .reset(reset), .start(st[0]), .amount(amt[0]),
    .pulse5000(p5[0]), .pulse2000(p2[0]), .pulse1000(p1[0]),
    .busy(bz[0]), .done(dn[0]), .c_5000(c5[0]), .c_2000(c2[0]),
    .c_1000(c1[0]), .change_left(cl[0])
  );

  change_dispenser #(.PULSE_GAP(1)) u1 (
    .clock(clock), .reset(reset), .start(st[1]), .amount(amt[1]),
    .pulse5000(p5[1]), .pulse2000(p2[1]), .pulse1000(p1[1]),
    .busy(bz[1]), .done(dn[1]), .c_5000(c5[1]), .c_2000(c2[1]),
    .c_1000(c1[1]), .change_left(cl[1])
  );

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Model: outputs follow from the pulse schedule implied by the greedy split.
  int G [2] = '{3, 1};
  bit m_act [2];
  int m_j [2], m_amt [2], m_n5 [2], m_n2 [2], m_n1 [2], m_nt [2];
  logic [1:0] ep5, ep2, ep1, ebz, edn;
  logic [6:0] ec5 [2];
  logic [7:0] ec2 [2];
  logic [8:0] ec1 [2];
  logic [9:0] ecl [2];

  initial begin
    ep5 = '0; ep2 = '0; ep1 = '0; ebz = '0; edn = '0;
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 0; ec5[u] = '0; ec2[u] = '0; ec1[u] = '0; ecl[u] = '0;
    end
    forever begin
      @(posedge clock);
      for (int u = 0; u < 2; u++) begin
        int per, m, p;
        per = G[u] + 1;
        if (reset) begin
          m_act[u] = 0;
          ep5[u] = 0; ep2[u] = 0; ep1[u] = 0; ebz[u] = 0; edn[u] = 0;
          ec5[u] = '0; ec2[u] = '0; ec1[u] = '0; ecl[u] = '0;
        end else begin
          ep5[u] = 0; ep2[u] = 0; ep1[u] = 0; edn[u] = 0;
          if (!m_act[u] && st[u]) begin
            m_act[u] = 1;
            m_j[u]   = 0;
            m_amt[u] = int'(amt[u]);
            m_n5[u]  = m_amt[u] / 5000;
            m_n2[u]  = (m_amt[u] % 5000) / 2000;
            m_n1[u]  = ((m_amt[u] % 5000) % 2000) / 1000;
            m_nt[u]  = m_n5[u] + m_n2[u] + m_n1[u];
            ebz[u] = 1; ec5[u] = '0; ec2[u] = '0; ec1[u] = '0; ecl[u] = '0;
          end else if (m_act[u]) begin
            m_j[u]++;
            m = m_j[u] - 1;
            if (m == m_nt[u] * per) begin
              edn[u] = 1; ebz[u] = 0; m_act[u] = 0;
              ecl[u] = 10'(m_amt[u] % 1000);
            end else if (m % per == 0) begin
              p = m / per;
              if (p < m_n5[u]) begin
                ep5[u] = 1; ec5[u] = ec5[u] + 7'd1;
              end else if (p < m_n5[u] + m_n2[u]) begin
                ep2[u] = 1; ec2[u] = ec2[u] + 8'd1;
              end else begin
                ep1[u] = 1; ec1[u] = ec1[u] + 9'd1;
              end
            end
          end
        end
      end
    end
  end

  function automatic logic [38:0] act_pk(input int u);
    return {p5[u], p2[u], p1[u], bz[u], dn[u], c5[u], c2[u], c1[u], cl[u]};
  endfunction

  function automatic logic [38:0] exp_pk(input int u);
    return {ep5[u], ep2[u], ep1[u], ebz[u], edn[u], ec5[u], ec2[u], ec1[u], ecl[u]};
  endfunction

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("model_u%0d", u), 64'(act_pk(u)), 64'(exp_pk(u)));
        chk($sformatf("onehot_u%0d", u),
            64'($countones({p5[u], p2[u], p1[u]}) > 1), 64'(0));
      end
    end
  end

  // Launch one transaction from a negedge; returns at the negedge showing done.
  task automatic xact(input int u, input logic [18:0] a, input int maxc,
                      input bit hold, input logic [18:0] a2,
                      output int t5, output int t2, output int t1, output int td,
                      output int n5, output int n2, output int n1, output int nb);
    int k;
    t5 = -1; t2 = -1; t1 = -1; td = -1;
    n5 = 0; n2 = 0; n1 = 0; nb = 0;
    st[u] = 1'b1;
    amt[u] = a;
    @(posedge clock);
    @(negedge clock);
    k = cyc;
    if (hold) amt[u] = a2;
    else st[u] = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      if (bz[u]) nb++;
      if (p5[u]) begin n5++; if (t5 < 0) t5 = cyc - k; end
      if (p2[u]) begin n2++; if (t2 < 0) t2 = cyc - k; end
      if (p1[u]) begin n1++; if (t1 < 0) t1 = cyc - k; end
      if (dn[u]) begin td = cyc - k; break; end
      @(negedge clock);
    end
    chk("done_seen", 64'(td >= 0), 64'(1));
  endtask

  task automatic wait_done(input int u, input int maxc, output int td);
    td = -1;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clock);
      if (dn[u]) begin td = n; break; end
    end
    chk("wait_done_seen", 64'(td >= 0), 64'(1));
  endtask

  initial begin
    int t5, t2, t1, td, n5, n2, n1, nb, k;
    reset = 1'b1;
    st = '0;
    amt[0] = '0;
    amt[1] = '0;
    @(posedge clock);
    chk_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("reset_u3", 64'(act_pk(0)), 64'(0));
    chk("reset_u1", 64'(act_pk(1)), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    // 8000 with gap 3
    xact(0, 19'd8000, 40, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("8000_t5", 64'(t5), 64'(1));
    chk("8000_t2", 64'(t2), 64'(5));
    chk("8000_t1", 64'(t1), 64'(9));
    chk("8000_done", 64'(td), 64'(13));
    chk("8000_counts", 64'({c5[0], c2[0], c1[0], cl[0]}),
        64'({7'd1, 8'd1, 9'd1, 10'd0}));
    @(negedge clock);

    // 17500 with gap 1
    xact(1, 19'd17500, 40, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("17500_n", 64'({n5[7:0], n2[7:0], n1[7:0]}), 64'({8'd3, 8'd1, 8'd0}));
    chk("17500_t2", 64'(t2), 64'(7));
    chk("17500_done", 64'(td), 64'(9));
    chk("17500_counts", 64'({c5[1], c2[1], c1[1], cl[1]}),
        64'({7'd3, 8'd1, 9'd0, 10'd500}));
    @(negedge clock);

    // below the smallest denomination
    xact(0, 19'd0, 10, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("zero_done", 64'(td), 64'(1));
    chk("zero_busy", 64'(nb), 64'(1));
    chk("zero_left", 64'(cl[0]), 64'(0));
    chk("zero_pulses", 64'(n5 + n2 + n1), 64'(0));
    @(negedge clock);
    xact(0, 19'd999, 10, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("999_done", 64'(td), 64'(1));
    chk("999_busy", 64'(nb), 64'(1));
    chk("999_left", 64'(cl[0]), 64'(999));
    @(negedge clock);

    // start held, amount changed mid-transaction
    xact(0, 19'd12000, 40, 1, 19'd50000, t5, t2, t1, td, n5, n2, n1, nb);
    chk("hold_n", 64'({n5[7:0], n2[7:0], n1[7:0]}), 64'({8'd2, 8'd1, 8'd0}));
    chk("hold_done", 64'(td), 64'(13));
    @(negedge clock);
    chk("hold_restart_busy", 64'(bz[0]), 64'(1));
    chk("hold_restart_c5", 64'(c5[0]), 64'(0));
    st[0] = 1'b0;
    wait_done(0, 60, td);
    chk("50000_done", 64'(td), 64'(41));
    chk("50000_c5", 64'(c5[0]), 64'(10));
    @(negedge clock);

    // reset during dispensing
    st[0] = 1'b1;
    amt[0] = 19'd30000;
    @(posedge clock);
    @(negedge clock);
    k = cyc;
    st[0] = 1'b0;
    n5 = 0;
    for (int n = 0; n < 6; n++) begin
      if (p5[0]) n5++;
      @(negedge clock);
    end
    chk("rst_prior_pulses", 64'(n5), 64'(2));
    chk("rst_offset", 64'(cyc - k), 64'(6));
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_u3", 64'(act_pk(0)), 64'(0));
    reset = 1'b0;
    for (int n = 0; n < 3; n++) @(negedge clock);
    xact(0, 19'd4000, 40, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("4000_n", 64'({n5[7:0], n2[7:0], n1[7:0]}), 64'({8'd0, 8'd2, 8'd0}));
    chk("4000_c2", 64'(c2[0]), 64'(2));
    @(negedge clock);

    // maximum amount
    xact(0, 19'd524287, 600, 0, '0, t5, t2, t1, td, n5, n2, n1, nb);
    chk("max_counts", 64'({c5[0], c2[0], c1[0], cl[0]}),
        64'({7'd104, 8'd2, 9'd0, 10'd287}));
    chk("max_done", 64'(td), 64'(425));
    for (int n = 0; n < 4; n++) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
